mem_boot_loader: RTL and testbench
==================================

Name: mem_boot_loader

Overview:
- Loads a program/data image into the 8-stage core's memory from a byte-stream handshake, then releases the core.
- Holds the core in reset and assembles four big-endian bytes into each 32-bit word.
- Writes words to consecutive word addresses through a single-cycle memory write port.
- Deasserts core_reset once the requested word count is written; it is the write-side counterpart of the bench-side memory dump.

Parameters:
- ADDR_WIDTH, 8, word-address width of the target memory.
- DATA_WIDTH, 32, memory word width; fixed at 4 bytes.
- BASE_ADDR, 0, word address of the first written word.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle pulse; begins a load, honoured only in IDLE or DONE.
- word_count  input  ADDR_WIDTH+1  number of words to load; sampled on the accepted start.
- in_valid  input  1  byte-stream valid.
- in_data  input  8  byte-stream data.
- in_ready  output  1  loader can accept a byte.
- mem_we  output  1  memory write enable, one cycle per word.
- mem_addr  output  ADDR_WIDTH  word address.
- mem_wdata  output  DATA_WIDTH  assembled word.
- core_reset  output  1  active-high reset to the core.
- busy  output  1  load in progress (LOAD or WRITE).
- done  output  1  image loaded.

Behaviour:
- Reset values: in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, core_reset=1, busy=0, done=0. The FSM enters IDLE and all counters clear.
- States and transitions:
  - IDLE: waits for start.
  - LOAD: in_ready=1; collecting bytes.
  - WRITE: in_ready=0; mem_we=1 for exactly one cycle.
  - DONE: done=1, core_reset=0.
- start accepted in IDLE or DONE:
  - latch word_count into remaining; word index=0; byte count=0.
  - drive core_reset=1 and done=0 from the next cycle.
  - next state is LOAD, or DONE if word_count=0 (no write occurs).
- start while busy is ignored; no state, counter or output changes.
- Byte transfer occurs on a cycle with in_valid && in_ready.
  - Bytes 0..3 of a word fill mem_wdata[31:24], [23:16], [15:8], [7:0] in that order.
  - Idle cycles (in_valid=0) may appear anywhere between bytes with no effect.
- Write timing: when the 4th byte transfers at edge k:
  - cycle k+1: WRITE, mem_we=1, mem_addr=(BASE_ADDR+index) mod 2^ADDR_WIDTH, mem_wdata=full word, in_ready=0.
  - cycle k+2: mem_we=0, index increments, remaining decrements. Next state is LOAD if remaining>0, otherwise DONE.
- mem_addr and mem_wdata hold their last values outside WRITE; only mem_we qualifies them.
- done and core_reset change together on entry to DONE. DONE persists until a new start or reset.
- Address wrap: BASE_ADDR+index wraps modulo 2^ADDR_WIDTH with no error.
- Maximum word_count is 2^ADDR_WIDTH; the full memory is written once.
- busy = (state==LOAD || state==WRITE).
- Reset mid-operation:
  - immediate abort; no partial-word write; outputs go to reset values, core_reset=1.
  - bytes already transferred are discarded.
- Bytes presented while in_ready=0 are not consumed; the source must hold them.
- Throughput: 5 cycles per word minimum (4 bytes + 1 write).

Test Plan:
- Load Fibonacci seeds: start, word_count=3, bytes 00 00 00 00, 00 00 00 01, 00 00 00 01.
  - Expect writes addr0=0, addr1=1, addr2=1, each mem_we exactly 1 cycle.
  - Expect done and core_reset=0 on the same cycle, 1 cycle after the last write.
- Byte order: word_count=1, bytes DE AD BE EF -> mem_wdata=32'hDEADBEEF at addr BASE_ADDR; in_ready=0 during the write cycle.
- Backpressure: random in_valid gaps of 0-3 cycles over 10 words -> the same 10 writes and values as the gap-free run, with 10 mem_we pulses total.
- word_count=0 -> no mem_we; DONE reached 1 cycle after start.
- start pulsed during LOAD of a 4-word load -> ignored; exactly 4 writes occur.
- Wrap: BASE_ADDR=254, ADDR_WIDTH=8, word_count=4 -> writes to addresses 254, 255, 0, 1.
- Reset mid-load: reset low after 2 bytes of word 1 -> mem_we never pulses for that word; outputs return to reset values.
- Reset recovery: after the mid-load reset, a new start with word_count=1 loads correctly into BASE_ADDR.

Source files
------------

// File: rtl/mem_boot_loader.sv
// mem_boot_loader: loads a word image from a byte stream into a single-port
// memory while holding the core in reset, then releases the core.
// Bytes arrive big-endian: the first byte of each group of four is bits [31:24].
module mem_boot_loader #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 32,
   parameter int BASE_ADDR  = 0
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [ADDR_WIDTH:0]   word_count,
   input  logic                  in_valid,
   input  logic [7:0]            in_data,
   output logic                  in_ready,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   output logic                  core_reset,
   output logic                  busy,
   output logic                  done
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_WRITE = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   localparam logic [ADDR_WIDTH-1:0] BASE_W = ADDR_WIDTH'(BASE_ADDR);

   state_t                  state_q, state_d;
   logic [ADDR_WIDTH:0]     remaining_q, remaining_d;
   logic [ADDR_WIDTH-1:0]   index_q, index_d;
   logic [1:0]              byte_cnt_q, byte_cnt_d;
   // Only the first three bytes need holding; the fourth goes straight into the word.
   logic [DATA_WIDTH-9:0]   shift_q, shift_d;
   logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
   logic [DATA_WIDTH-1:0]   mem_wdata_q, mem_wdata_d;
   logic                    in_ready_q, in_ready_d;
   logic                    mem_we_q, mem_we_d;
   logic                    core_reset_q, core_reset_d;
   logic                    busy_q, busy_d;
   logic                    done_q, done_d;
   logic                    byte_xfer_s;

   // Next-state, counter and registered-output computation.
   always_comb begin
      state_d     = state_q;
      remaining_d = remaining_q;
      index_d     = index_q;
      byte_cnt_d  = byte_cnt_q;
      shift_d     = shift_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      // in_ready_q is only ever high in LOAD, so this is the handshake.
      byte_xfer_s = in_valid && in_ready_q;

      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               remaining_d = word_count;
               index_d     = '0;
               byte_cnt_d  = 2'd0;
               shift_d     = '0;
               state_d     = (word_count == '0) ? ST_DONE : ST_LOAD;
            end else begin
               state_d = state_q;
            end
         end
         ST_LOAD: begin
            // start is deliberately not looked at here: a load cannot be restarted.
            if (byte_xfer_s) begin
               shift_d    = {shift_q[DATA_WIDTH-17:0], in_data};
               byte_cnt_d = byte_cnt_q + 2'd1;
               if (byte_cnt_q == 2'd3) begin
                  state_d     = ST_WRITE;
                  mem_wdata_d = {shift_q, in_data};
                  mem_addr_d  = BASE_W + index_q;
               end else begin
                  state_d = ST_LOAD;
               end
            end else begin
               state_d = ST_LOAD;
            end
         end
         ST_WRITE: begin
            index_d     = index_q + ADDR_WIDTH'(1);
            remaining_d = remaining_q - (ADDR_WIDTH+1)'(1);
            state_d     = (remaining_q > (ADDR_WIDTH+1)'(1)) ? ST_LOAD : ST_DONE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Outputs are registered images of the state being entered.
      in_ready_d   = (state_d == ST_LOAD);
      mem_we_d     = (state_d == ST_WRITE);
      busy_d       = (state_d == ST_LOAD) || (state_d == ST_WRITE);
      done_d       = (state_d == ST_DONE);
      core_reset_d = (state_d != ST_DONE);
   end

   // State, counters and output registers; async active-low reset.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= ST_IDLE;
         remaining_q  <= '0;
         index_q      <= '0;
         byte_cnt_q   <= 2'd0;
         shift_q      <= '0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
         in_ready_q   <= 1'b0;
         mem_we_q     <= 1'b0;
         core_reset_q <= 1'b1;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         remaining_q  <= remaining_d;
         index_q      <= index_d;
         byte_cnt_q   <= byte_cnt_d;
         shift_q      <= shift_d;
         mem_addr_q   <= mem_addr_d;
         mem_wdata_q  <= mem_wdata_d;
         in_ready_q   <= in_ready_d;
         mem_we_q     <= mem_we_d;
         core_reset_q <= core_reset_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
      end
   end

   assign in_ready   = in_ready_q;
   assign mem_we     = mem_we_q;
   assign mem_addr   = mem_addr_q;
   assign mem_wdata  = mem_wdata_q;
   assign core_reset = core_reset_q;
   assign busy       = busy_q;
   assign done       = done_q;

endmodule

// File: tb/tb_mem_boot_loader.sv
// Bench for mem_boot_loader: two instances (base 0 and base 254) share one
// byte stream; a reference model queues the expected (address, word) writes
// and a monitor pops and compares on every mem_we pulse.
module tb_mem_boot_loader;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset, start, in_valid;
   logic [8:0] word_count;
   logic [7:0] in_data;

   logic        in_ready0, mem_we0, core_reset0, busy0, done0;
   logic [7:0]  mem_addr0;
   logic [31:0] mem_wdata0;
   logic        in_ready1, mem_we1, core_reset1, busy1, done1;
   logic [7:0]  mem_addr1;
   logic [31:0] mem_wdata1;

   mem_boot_loader #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .BASE_ADDR(0)) dut0 (
      .clk(clk), .reset(reset), .start(start), .word_count(word_count),
      .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready0),
      .mem_we(mem_we0), .mem_addr(mem_addr0), .mem_wdata(mem_wdata0),
      .core_reset(core_reset0), .busy(busy0), .done(done0));

   mem_boot_loader #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .BASE_ADDR(254)) dut1 (
      .clk(clk), .reset(reset), .start(start), .word_count(word_count),
      .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready1),
      .mem_we(mem_we1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
      .core_reset(core_reset1), .busy(busy1), .done(done1));

   int n_checks = 0;
   int n_fail   = 0;
   int writes0  = 0;
   int writes1  = 0;
   int expected_writes = 0;
   logic prev_we0 = 1'b0;
   logic prev_we1 = 1'b0;
   logic [39:0] exp_q0[$];
   logic [39:0] exp_q1[$];
   logic [31:0] words_q[$];
   logic [39:0] e0, e1;

   task automatic chk(input string name, input logic [39:0] act, input logic [39:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: word i lands at (base + i) mod 256.
   task automatic push_expect(input int idx, input logic [31:0] w);
      exp_q0.push_back({8'((0 + idx) % 256), w});
      exp_q1.push_back({8'((254 + idx) % 256), w});
      expected_writes++;
   endtask

   // Monitor: every mem_we pulse is popped against the scoreboard.
   always @(negedge clk) begin
      if (mem_we0) begin
         writes0++;
         chk("we0_single_cycle", {39'd0, prev_we0}, 40'd0);
         chk("ready0_low_in_write", {39'd0, in_ready0}, 40'd0);
         if (exp_q0.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL unexpected_write0: got %0h expected none", {mem_addr0, mem_wdata0});
         end else begin
            e0 = exp_q0.pop_front();
            chk("write0", {mem_addr0, mem_wdata0}, e0);
         end
      end
      prev_we0 = mem_we0;
      if (mem_we1) begin
         writes1++;
         chk("we1_single_cycle", {39'd0, prev_we1}, 40'd0);
         if (exp_q1.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL unexpected_write1: got %0h expected none", {mem_addr1, mem_wdata1});
         end else begin
            e1 = exp_q1.pop_front();
            chk("write1", {mem_addr1, mem_wdata1}, e1);
         end
      end
      prev_we1 = mem_we1;
   end

   // All stimulus tasks begin and end just after a falling edge.
   task automatic do_start(input int wc);
      start = 1'b1;
      word_count = 9'(wc);
      @(negedge clk);
      start = 1'b0;
      word_count = 9'd0;
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap);
      int t;
      repeat (gap) @(negedge clk);
      in_valid = 1'b1;
      in_data  = b;
      t = 0;
      while (in_ready0 !== 1'b1 && t < 50) begin
         @(negedge clk);
         t++;
      end
      if (t >= 50) begin
         n_checks++; n_fail++;
         $display("FAIL byte_timeout: in_ready stayed %b expected 1", in_ready0);
      end
      @(negedge clk);
      in_valid = 1'b0;
      in_data  = 8'h00;
   endtask

   task automatic run_load(input int wc, input int max_gap, input bit inject_start);
      logic [31:0] w;
      for (int i = 0; i < wc; i++) push_expect(i, words_q[i]);
      do_start(wc);
      chk("busy_after_start", {39'd0, busy0}, 40'd1);
      chk("core_reset_after_start", {39'd0, core_reset0}, 40'd1);
      chk("done_low_after_start", {39'd0, done0}, 40'd0);
      for (int i = 0; i < wc; i++) begin
         w = words_q[i];
         for (int j = 0; j < 4; j++) begin
            if (inject_start && i == 1 && j == 2) begin
               start = 1'b1;
               word_count = 9'd9;
               @(negedge clk);
               start = 1'b0;
               word_count = 9'd0;
               chk("busy_after_ignored_start", {39'd0, busy0}, 40'd1);
            end
            send_byte(w[31-8*j -: 8], $urandom_range(0, max_gap));
         end
      end
      chk("done_low_in_last_write", {39'd0, done0}, 40'd0);
      chk("core_reset_in_last_write", {39'd0, core_reset0}, 40'd1);
      @(negedge clk);
      chk("done_after_load", {39'd0, done0}, 40'd1);
      chk("core_reset_released", {39'd0, core_reset0}, 40'd0);
      chk("busy_low_done", {39'd0, busy0}, 40'd0);
      chk("done1_after_load", {39'd0, done1}, 40'd1);
      chk("queue0_drained", 40'(exp_q0.size()), 40'd0);
      chk("queue1_drained", 40'(exp_q1.size()), 40'd0);
   endtask

   task automatic check_reset_values();
      chk("rst_in_ready", {39'd0, in_ready0}, 40'd0);
      chk("rst_mem_we", {39'd0, mem_we0}, 40'd0);
      chk("rst_mem_addr", {32'd0, mem_addr0}, 40'd0);
      chk("rst_mem_wdata", {8'd0, mem_wdata0}, 40'd0);
      chk("rst_core_reset", {39'd0, core_reset0}, 40'd1);
      chk("rst_busy", {39'd0, busy0}, 40'd0);
      chk("rst_done", {39'd0, done0}, 40'd0);
      chk("rst_mem_addr1", {32'd0, mem_addr1}, 40'd0);
      chk("rst_mem_wdata1", {8'd0, mem_wdata1}, 40'd0);
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int w_before;
      reset = 1'b0; start = 1'b0; word_count = 9'd0; in_valid = 1'b0; in_data = 8'h00;
      repeat (3) @(negedge clk);
      check_reset_values();
      reset = 1'b1;
      @(negedge clk);

      // Fibonacci seeds
      words_q = '{32'h0, 32'h1, 32'h1};
      run_load(3, 0, 1'b0);

      // Byte order
      words_q = '{32'hDEADBEEF};
      run_load(1, 0, 1'b0);

      // Ten random words, gap-free then with random gaps
      words_q.delete();
      for (int i = 0; i < 10; i++) words_q.push_back($urandom);
      run_load(10, 0, 1'b0);
      run_load(10, 3, 1'b0);

      // Zero-length load
      w_before = writes0;
      do_start(0);
      chk("wc0_done", {39'd0, done0}, 40'd1);
      chk("wc0_busy", {39'd0, busy0}, 40'd0);
      chk("wc0_core_reset", {39'd0, core_reset0}, 40'd0);
      repeat (3) @(negedge clk);
      chk("wc0_no_write", 40'(writes0 - w_before), 40'd0);

      // start pulsed mid-load is ignored; wrap covered on the base-254 instance
      words_q.delete();
      for (int i = 0; i < 4; i++) words_q.push_back($urandom);
      run_load(4, 1, 1'b1);

      // Reset mid-load: word 0 completes, word 1 aborted after two bytes
      words_q.delete();
      for (int i = 0; i < 3; i++) words_q.push_back($urandom);
      push_expect(0, words_q[0]);
      do_start(3);
      for (int j = 0; j < 4; j++) send_byte(words_q[0][31-8*j -: 8], 0);
      send_byte(words_q[1][31:24], 0);
      send_byte(words_q[1][23:16], 0);
      reset = 1'b0;
      #1;
      check_reset_values();
      repeat (3) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      chk("abort_no_write_q0", 40'(exp_q0.size()), 40'd0);
      chk("abort_still_idle", {39'd0, busy0}, 40'd0);

      // Recovery
      words_q = '{32'hC0FFEE11};
      run_load(1, 2, 1'b0);

      repeat (3) @(negedge clk);
      chk("writes0_total", 40'(writes0), 40'(expected_writes));
      chk("writes1_total", 40'(writes1), 40'(expected_writes));
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
